// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master drives start/bcd_in; the slave (converter) returns status and the result.
interface bcd_to_bin_if #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   modport master (
      output start, bcd_in,
      input  ready, busy, done, bin_out, err
   );

   modport slave (
      input  start, bcd_in,
      output ready, busy, done, bin_out, err
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic         clk,
   input  logic         reset,
   bcd_to_bin_if.slave  bus
);
   localparam int BCD_W  = 4 * DIGITS;
   localparam int ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ERR   = 2'd2
   } state_t;

   state_t              state;
   logic [BCD_W-1:0]    bcd_reg;
   logic [BIN_W-1:0]    bin_reg;
   logic [ITER_W-1:0]   iter;

   logic [BCD_W-1:0]    shift_bcd;
   logic [BCD_W-1:0]    adj_bcd;
   logic [BIN_W-1:0]    shift_bin;

`ifdef BCD_DIGIT_CHECK_EN
   function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction
`endif

   // One reverse double-dabble step: shift right, then digits >= 8 lose 3.
   always_comb begin
      shift_bcd = {1'b0, bcd_reg[BCD_W-1:1]};
      shift_bin = {bcd_reg[0], bin_reg[BIN_W-1:1]};
      adj_bcd   = shift_bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (shift_bcd[4*d+3]) begin
            adj_bcd[4*d +: 4] = shift_bcd[4*d +: 4] - 4'd3;
         end else begin
            adj_bcd[4*d +: 4] = shift_bcd[4*d +: 4];
         end
      end
   end

`ifndef BCD_DIGIT_CHECK_EN
   assign bus.err = 1'b0;
`endif

   // Control FSM, work registers and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         iter        <= '0;
         bus.ready   <= 1'b1;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.bin_out <= '0;
`ifdef BCD_DIGIT_CHECK_EN
         bus.err     <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bcd_reg   <= bus.bcd_in;
                  bin_reg   <= '0;
                  iter      <= '0;
                  bus.ready <= 1'b0;
                  bus.busy  <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                  state     <= has_bad_digit(bus.bcd_in) ? ERR : SHIFT;
`else
                  state     <= SHIFT;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               bcd_reg <= adj_bcd;
               bin_reg <= shift_bin;
               if (iter == ITER_W'(BIN_W - 1)) begin
                  bus.bin_out <= shift_bin;
`ifdef BCD_DIGIT_CHECK_EN
                  bus.err     <= 1'b0;
`endif
                  bus.done    <= 1'b1;
                  bus.ready   <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= IDLE;
               end else begin
                  iter <= iter + ITER_W'(1);
               end
            end
`ifdef BCD_DIGIT_CHECK_EN
            ERR: begin
               bus.bin_out <= '0;
               bus.err     <= 1'b1;
               bus.done    <= 1'b1;
               bus.ready   <= 1'b1;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end
`endif
            default: begin
               state     <= IDLE;
               bus.ready <= 1'b1;
               bus.busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq; define BCD_DIGIT_CHECK_EN to cover
// the invalid-digit path as well.
module tb_bcd_to_bin_seq;
   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Single conversion; latency counts clocks from the accept edge (inclusive) to done.
   task automatic convert(input string tag, input logic [15:0] bcd, input int exp_bin,
                          input int exp_lat, input logic exp_err);
      int lat;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_value({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check_value({tag, "_ready_lo"}, 32'(bus.ready), 32'd0);
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_value({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_value({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
      check_value({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      check_value({tag, "_ready_on_done"}, 32'(bus.ready), 32'd1);
      @(posedge clk);
      #1;
      check_value({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [15:0] ops  [3];
      int          exps [3];
      int          k;
      int          cyc;
      int          last;
      int          dones;

      n_checks   = 0;
      n_fails    = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.bcd_in = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check_value("rst_ready", 32'(bus.ready), 32'd1);
      check_value("rst_busy", 32'(bus.busy), 32'd0);
      check_value("rst_done", 32'(bus.done), 32'd0);
      check_value("rst_bin", 32'(bus.bin_out), 32'd0);
      check_value("rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      convert("c1234", 16'h1234, 1234, 15, 1'b0);
      convert("c9999", 16'h9999, 9999, 15, 1'b0);
      convert("c0000", 16'h0000, 0, 15, 1'b0);
      convert("c0001", 16'h0001, 1, 15, 1'b0);
      convert("c5080", 16'h5080, 5080, 15, 1'b0);

      // Back-to-back: start held high, new operand presented in each done cycle.
      ops[0] = 16'h0512; exps[0] = 512;
      ops[1] = 16'h8080; exps[1] = 8080;
      ops[2] = 16'h0999; exps[2] = 999;
      k = 0; cyc = 0; last = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = ops[0];
      while (k < 3 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done) begin
            check_value($sformatf("b2b_bin%0d", k), 32'(bus.bin_out), 32'(exps[k]));
            if (k > 0) begin
               check_value($sformatf("b2b_period%0d", k), 32'(cyc - last), 32'd15);
            end
            last = cyc;
            k++;
            if (k < 3) begin
               bus.bcd_in = ops[k];
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check_value("b2b_count", 32'(k), 32'd3);

      // Start pulsed at cycles 3 and 8 of a conversion must be ignored.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 16'h0777;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.bcd_in = 16'h0555;
      dones = 0; last = 0;
      for (int c = 1; c <= 35; c++) begin
         bus.start = (c == 3 || c == 8) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         if (bus.done) begin
            dones++;
            last = 32'(bus.bin_out);
         end
      end
      bus.start = 1'b0;
      check_value("ign_dones", 32'(dones), 32'd1);
      check_value("ign_bin", 32'(last), 32'd777);

      // Reset during SHIFT iteration 5 aborts the conversion.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 16'h2468;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_value("midrst_ready", 32'(bus.ready), 32'd1);
      check_value("midrst_busy", 32'(bus.busy), 32'd0);
      check_value("midrst_bin", 32'(bus.bin_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check_value("midrst_no_done", 32'(dones), 32'd0);

`ifdef BCD_DIGIT_CHECK_EN
      convert("bad12A4", 16'h12A4, 0, 2, 1'b1);
      convert("c0042", 16'h0042, 42, 15, 1'b0);
`else
      convert("c0042", 16'h0042, 42, 15, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
